// File: rtl/wrclk_dcm_pkg.sv
// Shared state encoding and default timing parameters for the WRCLK DCM supervisor.
package wrclk_dcm_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_RESET     = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [STATE_W-1:0] ST_STABLE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_LOCKED    = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAULT     = 3'd4;

    localparam int DEF_RESET_CYCLES  = 100;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 256;
    localparam int DEF_MAX_RETRIES   = 4;

    // Sizes the shared phase counter from the longest phase.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dcm_signal_sync.sv
// Two-flop synchronizer for DCM status signals that are asynchronous to clk_i.
module dcm_signal_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/wrclk_dcm_supervisor.sv
// WRCLK DCM supervisor: sequences DCM reset, waits for and qualifies lock,
// retries a bounded number of times and parks in a sticky fault.
module wrclk_dcm_supervisor
    import wrclk_dcm_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       dcm_locked_i,
    input  logic [2:0] dcm_status_i,
    input  logic       enable_i,
    input  logic       sw_reset_req_i,
    input  logic       clear_i,
    output logic       dcm_reset_o,
    output logic       locked_o,
    output logic       fault_o,
    output logic [7:0] relock_count_o,
    output logic [2:0] state_o
);

    localparam int CNT_W = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic [1:0] sync_s;
    logic       good;
    logic       unused_status;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         retries_q, retries_d;
    logic [7:0]         relock_q, relock_d;
    logic               dcm_reset_q, locked_q, fault_q;
    logic               fail, lost;

    dcm_signal_sync #(.WIDTH(2)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i ({dcm_status_i[1], dcm_locked_i}),
        .sync_o  (sync_s)
    );

    assign good          = sync_s[0] & ~sync_s[1];
    assign unused_status = ^{dcm_status_i[2], dcm_status_i[0]};

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        relock_d  = relock_q;
        fail      = 1'b0;
        lost      = 1'b0;

        if (sw_reset_req_i && state_q != ST_RESET) begin
            state_d   = ST_RESET;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (good)                       state_d = ST_STABLE;
                    else if (cnt_q == TIMEOUT_LAST) fail    = 1'b1;
                end
                ST_STABLE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!good) begin
                        fail = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d   = ST_LOCKED;
                        retries_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!good) begin
                        lost    = 1'b1;
                        state_d = enable_i ? ST_RESET : ST_FAULT;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_RESET;
            endcase
        end

        if (fail) begin
            retries_d = retries_q + 4'd1;
            state_d   = (retries_d == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
        end

        if (lost && relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        if (clear_i)                   relock_d = '0;

        // Each phase measures its own duration from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            retries_q   <= '0;
            relock_q    <= '0;
            dcm_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            relock_q    <= relock_d;
            dcm_reset_q <= (state_d == ST_RESET);
            locked_q    <= (state_d == ST_LOCKED);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign dcm_reset_o    = dcm_reset_q;
    assign locked_o       = locked_q;
    assign fault_o        = fault_q;
    assign relock_count_o = relock_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_wrclk_dcm_supervisor.sv
// Bench for wrclk_dcm_supervisor: countdown-based phase model compared every cycle,
// plus directed scenarios with hand-computed cycle positions and counts.
module tb_wrclk_dcm_supervisor;

    localparam int RC = 100;
    localparam int LT = 1000;
    localparam int SC = 256;
    localparam int MR = 4;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b1;
    logic       dcm_locked_i = 1'b0;
    logic [2:0] dcm_status_i = 3'b000;
    logic       enable_i = 1'b1;
    logic       sw_reset_req_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       dcm_reset_o, locked_o, fault_o;
    logic [7:0] relock_count_o;
    logic [2:0] state_o;

    logic       sat_locked_i = 1'b1;
    logic       sat_zero = 1'b0;
    logic       sat_one = 1'b1;
    logic [2:0] sat_status = 3'b000;
    logic       sat_dcm_reset_o, sat_locked_o, sat_fault_o;
    logic [7:0] sat_relock_count_o;
    logic [2:0] sat_state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic cmp_en = 1'b0;

    always #5 clk_i = ~clk_i;

    wrclk_dcm_supervisor #(
        .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .dcm_locked_i(dcm_locked_i),
        .dcm_status_i(dcm_status_i), .enable_i(enable_i),
        .sw_reset_req_i(sw_reset_req_i), .clear_i(clear_i),
        .dcm_reset_o(dcm_reset_o), .locked_o(locked_o), .fault_o(fault_o),
        .relock_count_o(relock_count_o), .state_o(state_o)
    );

    // Short-phase instance so the relock counter can be driven to saturation quickly.
    wrclk_dcm_supervisor #(
        .RESET_CYCLES(2), .LOCK_TIMEOUT(20), .STABLE_CYCLES(4), .MAX_RETRIES(2)
    ) dut_sat (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .dcm_locked_i(sat_locked_i),
        .dcm_status_i(sat_status), .enable_i(sat_one),
        .sw_reset_req_i(sat_zero), .clear_i(sat_zero),
        .dcm_reset_o(sat_dcm_reset_o), .locked_o(sat_locked_o), .fault_o(sat_fault_o),
        .relock_count_o(sat_relock_count_o), .state_o(sat_state_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {P_RESET, P_WAIT, P_STABLE, P_LOCKED, P_FAULT} phase_t;

    typedef struct {
        phase_t ph;
        int     left;
        int     tries;
        int     relocks;
        logic   s1l, s2l, s1c, s2c;
    } model_t;

    function automatic int phase_len(input phase_t p);
        case (p)
            P_RESET:  return RC;
            P_WAIT:   return LT;
            P_STABLE: return SC;
            default:  return 0;
        endcase
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.ph = P_RESET; m.left = RC; m.tries = 0; m.relocks = 0;
        m.s1l = 1'b0; m.s2l = 1'b0; m.s1c = 1'b0; m.s2c = 1'b0;
        return m;
    endfunction

    function automatic model_t model_next(input model_t m, input logic lk, input logic st,
                                          input logic en, input logic sw, input logic clr);
        model_t n;
        logic good, lost, fail;
        n = m;
        good = m.s2l & ~m.s2c;
        lost = 1'b0;
        fail = 1'b0;
        n.s1l = lk; n.s2l = m.s1l; n.s1c = st; n.s2c = m.s1c;
        if (sw && m.ph != P_RESET) begin
            n.ph = P_RESET;
            n.tries = 0;
        end else begin
            case (m.ph)
                P_RESET: begin
                    n.left = m.left - 1;
                    if (n.left == 0) n.ph = P_WAIT;
                end
                P_WAIT: begin
                    if (good) n.ph = P_STABLE;
                    else begin
                        n.left = m.left - 1;
                        if (n.left == 0) fail = 1'b1;
                    end
                end
                P_STABLE: begin
                    if (!good) fail = 1'b1;
                    else begin
                        n.left = m.left - 1;
                        if (n.left == 0) begin n.ph = P_LOCKED; n.tries = 0; end
                    end
                end
                P_LOCKED: if (!good) begin lost = 1'b1; n.ph = en ? P_RESET : P_FAULT; end
                default: ;
            endcase
        end
        if (fail) begin
            n.tries = m.tries + 1;
            n.ph = (n.tries == MR) ? P_FAULT : P_RESET;
        end
        if (lost) n.relocks = (m.relocks >= 255) ? 255 : m.relocks + 1;
        if (clr) n.relocks = 0;
        if (n.ph != m.ph) n.left = phase_len(n.ph);
        return n;
    endfunction

    function automatic logic [2:0] phase_code(input phase_t p);
        case (p)
            P_RESET:  return 3'd0;
            P_WAIT:   return 3'd1;
            P_STABLE: return 3'd2;
            P_LOCKED: return 3'd3;
            default:  return 3'd4;
        endcase
    endfunction

    model_t mdl = model_reset();

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mdl <= model_reset();
            cyc <= 0;
        end else begin
            mdl <= model_next(mdl, dcm_locked_i, dcm_status_i[1], enable_i, sw_reset_req_i, clear_i);
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en)
            check("outputs_vs_model",
                  {18'd0, dcm_reset_o, locked_o, fault_o, relock_count_o, state_o},
                  {18'd0, mdl.ph == P_RESET, mdl.ph == P_LOCKED, mdl.ph == P_FAULT,
                   8'(mdl.relocks), phase_code(mdl.ph)});
    end

    // ---------------- directed scenarios ----------------
    function automatic logic cond(input int sel);
        case (sel)
            0:       return dcm_reset_o == 1'b0;
            1:       return locked_o == 1'b1;
            2:       return locked_o == 1'b0;
            3:       return fault_o == 1'b1;
            4:       return state_o == 3'd2;
            5:       return sat_locked_o == 1'b1;
            6:       return sat_locked_o == 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (cond(sel)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: condition not met within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int at, c0, high, pulses, fault_at;
        logic prev;

        #1 rst_n_i = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_dcm_reset", dcm_reset_o, 1);
        check("rst_locked", locked_o, 0);
        check("rst_fault", fault_o, 0);
        check("rst_relock", relock_count_o, 0);
        check("rst_state", state_o, 0);

        // Lock never arrives: four pulses 0..99, 1100..1199, 2200..2299, 3300..3399, fault at 4400.
        rst_n_i = 1'b1;
        high = 0; pulses = 0; prev = 1'b0; fault_at = -1;
        for (int i = 0; i <= 4400; i++) begin
            if (i > 0) @(negedge clk_i);
            if (dcm_reset_o) high++;
            if (dcm_reset_o && !prev) pulses++;
            prev = dcm_reset_o;
            if (fault_o && fault_at < 0) fault_at = cyc;
        end
        check("t2_reset_high_cycles", high, 400);
        check("t2_reset_pulses", pulses, 4);
        check("t2_fault_cycle", fault_at, 4400);
        repeat (200) @(negedge clk_i);
        check("t2_fault_sticky", fault_o, 1);
        check("t2_state_fault", state_o, 4);
        check("t2_dcm_reset_low", dcm_reset_o, 0);

        // Reset release with lock present: pulse ends at edge 100, STABLE from 101, LOCKED at 357.
        rst_n_i = 1'b0;
        dcm_locked_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        wait_for("t1_pulse_end", 0, 200, at);
        check("t1_reset_pulse_len", at, 100);
        wait_for("t1_lock", 1, 400, at);
        check("t1_lock_rise_cycle", at, 357);
        check("t1_state_locked", state_o, 3);

        // Lock loss with recovery: locked_o falls 3 later, relock in 100+1+256 more.
        c0 = cyc;
        dcm_locked_i = 1'b0;
        wait_for("t3_loss", 2, 10, at);
        check("t3_loss_latency", at - c0, 3);
        check("t3_relock_count", relock_count_o, 1);
        check("t3_dcm_reset", dcm_reset_o, 1);
        repeat (7) @(negedge clk_i);
        dcm_locked_i = 1'b1;
        wait_for("t3_relock", 1, 400, at);
        check("t3_relock_cycle", at - c0, 360);

        // Informational status bits must not disturb lock; CLKIN stop with enable off faults.
        dcm_status_i = 3'b101;
        repeat (5) @(negedge clk_i);
        check("t4_status_ignored", locked_o, 1);
        enable_i = 1'b0;
        c0 = cyc;
        dcm_status_i = 3'b010;
        wait_for("t4_fault", 3, 10, at);
        check("t4_fault_latency", at - c0, 3);
        check("t4_relock_count", relock_count_o, 2);
        check("t4_state_fault", state_o, 4);
        check("t4_dcm_reset_low", dcm_reset_o, 0);
        repeat (5) @(negedge clk_i);
        dcm_status_i = 3'b000;
        repeat (5) @(negedge clk_i);
        check("t4_fault_held", fault_o, 1);
        sw_reset_req_i = 1'b1;
        @(negedge clk_i);
        sw_reset_req_i = 1'b0;
        check("t4_sw_fault_clear", fault_o, 0);
        check("t4_sw_state", state_o, 0);
        check("t4_sw_dcm_reset", dcm_reset_o, 1);
        enable_i = 1'b1;
        wait_for("t4_relock", 1, 400, at);

        // Software reset in the same cycle as the loss is seen: no increment.
        c0 = cyc;
        dcm_locked_i = 1'b0;
        repeat (2) @(negedge clk_i);
        sw_reset_req_i = 1'b1;
        @(negedge clk_i);
        sw_reset_req_i = 1'b0;
        check("t5_sw_priority_count", relock_count_o, 2);
        check("t5_sw_priority_state", state_o, 0);
        dcm_locked_i = 1'b1;
        wait_for("t5_relock_a", 1, 400, at);

        // Clear in the same cycle as an increment: clear wins.
        dcm_locked_i = 1'b0;
        repeat (2) @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("t5_clear_wins", relock_count_o, 0);
        check("t5_clear_state", state_o, 0);
        dcm_locked_i = 1'b1;
        wait_for("t5_relock_b", 1, 400, at);

        // Saturation on the short-phase instance.
        for (int k = 1; k <= 257; k++) begin
            wait_for("sat_lock", 5, 50, at);
            sat_locked_i = 1'b0;
            wait_for("sat_loss", 6, 10, at);
            sat_locked_i = 1'b1;
            check("sat_relock_count", sat_relock_count_o, (k > 255) ? 255 : k);
        end

        // Asynchronous reset in the middle of STABLE.
        dcm_locked_i = 1'b0;
        repeat (4) @(negedge clk_i);
        dcm_locked_i = 1'b1;
        wait_for("t6_stable", 4, 200, at);
        repeat (10) @(negedge clk_i);
        check("t6_in_stable", state_o, 2);
        #2 rst_n_i = 1'b0;
        #1;
        check("t6_async_dcm_reset", dcm_reset_o, 1);
        check("t6_async_locked", locked_o, 0);
        check("t6_async_state", state_o, 0);
        check("t6_async_relock", relock_count_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (5) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
